// File: rtl/game_start_ctrl_if.sv
// game_start_ctrl_if: button, timer and status signals between the game start controller and its surroundings.
interface game_start_ctrl_if;
    logic       btn_start;
    logic       btn_clear;
    logic       game_over;
    logic       timer_start;
    logic       timer_reset;
    logic [1:0] state;
    logic       led_running;
    logic       led_over;
    logic [7:0] game_count;
    modport master (
        output btn_start, btn_clear, game_over,
        input  timer_start, timer_reset, state, led_running, led_over, game_count
    );
    modport slave (
        input  btn_start, btn_clear, game_over,
        output timer_start, timer_reset, state, led_running, led_over, game_count
    );
endinterface

// File: rtl/game_start_ctrl.sv
// game_start_ctrl: debounces START/CLEAR and runs the game-flow FSM driving the countdown timer.
// Define AUTO_CLEAR_EN to leave OVER automatically after OVER_HOLD_CYCLES cycles.
module game_start_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int OVER_HOLD_CYCLES = 100000000
) (
    input logic              clock,
    input logic              reset,
    game_start_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUNNING  = 2'd1;
    localparam logic [1:0] OVER     = 2'd2;
    localparam logic [1:0] CLEARING = 2'd3;

    // bit 0 is START, bit 1 is CLEAR throughout the conditioning path
    logic [1:0]    raw, sync0, sync1, deb, ev;
    logic [DW-1:0] cnt [2];
    logic [1:0]    st, nxt;
    logic          auto_clr;

    assign raw = {bus.btn_clear, bus.btn_start};

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync0 <= '0;
            sync1 <= '0;
            deb   <= '0;
            ev    <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            for (int i = 0; i < 2; i++) begin
                ev[i] <= 1'b0;
                if (sync1[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    deb[i] <= sync1[i];
                    ev[i]  <= sync1[i];
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

`ifdef AUTO_CLEAR_EN
    localparam int HW = $clog2(OVER_HOLD_CYCLES + 1);
    logic [HW-1:0] hold;
    always_ff @(posedge clock) begin
        if (!reset) hold <= '0;
        else hold <= (st == OVER && nxt == OVER) ? hold + 1'b1 : '0;
    end
    assign auto_clr = hold == HW'(OVER_HOLD_CYCLES - 1);
`else
    logic unused_hold;
    assign unused_hold = ^OVER_HOLD_CYCLES;
    assign auto_clr    = 1'b0;
`endif

    // clear beats start and game_over; CLEARING always returns to IDLE
    always_comb begin
        nxt = (st == CLEARING)                  ? IDLE     :
              ev[1]                             ? CLEARING :
              (st == IDLE && ev[0])             ? RUNNING  :
              (st == RUNNING && bus.game_over)  ? OVER     :
              (st == OVER && auto_clr)          ? CLEARING : st;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            st              <= IDLE;
            bus.timer_start <= 1'b0;
            bus.timer_reset <= 1'b1;
            bus.led_running <= 1'b0;
            bus.led_over    <= 1'b0;
            bus.game_count  <= '0;
        end else begin
            st              <= nxt;
            bus.timer_start <= st == IDLE && nxt == RUNNING;
            bus.timer_reset <= nxt == CLEARING;
            bus.led_running <= nxt == RUNNING;
            bus.led_over    <= nxt == OVER;
            if (st == IDLE && nxt == RUNNING && bus.game_count != 8'hff)
                bus.game_count <= bus.game_count + 8'd1;
        end
    end

    assign bus.state = st;
endmodule

// File: tb/tb_game_start_ctrl.sv
// tb_game_start_ctrl: directed checks of debounce latency, FSM flow, priority and counter saturation.
module tb_game_start_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pulses;

    game_start_ctrl_if bus();

    game_start_ctrl #(.DEBOUNCE_CYCLES(4), .OVER_HOLD_CYCLES(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_pulses(input int n);
        pulses = 0;
        repeat (n) begin
            step(1);
            if (bus.timer_start) pulses++;
        end
    endtask

    initial begin
        bus.btn_start = 1'b0;
        bus.btn_clear = 1'b0;
        bus.game_over = 1'b0;
        // reset behaviour
        step(3);
        chk("reset_timer_reset", 32'(bus.timer_reset), 1);
        chk("reset_state", 32'(bus.state), 0);
        chk("reset_count", 32'(bus.game_count), 0);
        chk("reset_timer_start", 32'(bus.timer_start), 0);
        reset = 1'b1;
        step(1);
        chk("release_timer_reset", 32'(bus.timer_reset), 0);
        // held start: pulse exactly 7 edges after the rise
        bus.btn_start = 1'b1;
        step(6);
        chk("start_edge6", 32'(bus.timer_start), 0);
        step(1);
        chk("start_edge7", 32'(bus.timer_start), 1);
        chk("start_state", 32'(bus.state), 1);
        chk("start_count", 32'(bus.game_count), 1);
        chk("start_led_running", 32'(bus.led_running), 1);
        count_pulses(10);
        chk("held_no_repulse", 32'(pulses), 0);
        bus.btn_start = 1'b0;
        step(8);
        chk("release_still_running", 32'(bus.state), 1);
        // game_over in RUNNING, then clear
        bus.game_over = 1'b1;
        step(1);
        chk("over_state", 32'(bus.state), 2);
        chk("over_led", 32'(bus.led_over), 1);
        chk("over_led_running", 32'(bus.led_running), 0);
        bus.btn_clear = 1'b1;
        step(6);
        chk("clear_edge6_state", 32'(bus.state), 2);
        step(1);
        chk("clearing_state", 32'(bus.state), 3);
        chk("clearing_timer_reset", 32'(bus.timer_reset), 1);
        step(1);
        chk("after_clear_state", 32'(bus.state), 0);
        chk("after_clear_timer_reset", 32'(bus.timer_reset), 0);
        chk("clear_keeps_count", 32'(bus.game_count), 1);
        bus.btn_clear = 1'b0;
        bus.game_over = 1'b0;
        step(8);
        // glitch shorter than the debounce window
        bus.btn_start = 1'b1;
        step(3);
        bus.btn_start = 1'b0;
        count_pulses(12);
        chk("glitch_no_pulse", 32'(pulses), 0);
        chk("glitch_state", 32'(bus.state), 0);
        // simultaneous start and clear: clear wins
        bus.btn_start = 1'b1;
        bus.btn_clear = 1'b1;
        step(7);
        chk("both_state", 32'(bus.state), 3);
        chk("both_timer_start", 32'(bus.timer_start), 0);
        chk("both_count", 32'(bus.game_count), 1);
        step(1);
        chk("both_idle", 32'(bus.state), 0);
        bus.btn_start = 1'b0;
        bus.btn_clear = 1'b0;
        step(8);
        // OVER hold behaviour
        bus.btn_start = 1'b1;
        step(7);
        chk("game2_state", 32'(bus.state), 1);
        chk("game2_count", 32'(bus.game_count), 2);
        bus.btn_start = 1'b0;
        step(8);
        bus.game_over = 1'b1;
        step(1);
        chk("game2_over", 32'(bus.state), 2);
`ifdef AUTO_CLEAR_EN
        step(9);
        chk("auto_hold_over", 32'(bus.state), 2);
        step(1);
        chk("auto_clearing", 32'(bus.state), 3);
        chk("auto_timer_reset", 32'(bus.timer_reset), 1);
        step(1);
        chk("auto_idle", 32'(bus.state), 0);
`else
        step(101);
        chk("over_persists", 32'(bus.state), 2);
        bus.btn_clear = 1'b1;
        step(7);
        chk("manual_clearing", 32'(bus.state), 3);
        bus.btn_clear = 1'b0;
`endif
        bus.game_over = 1'b0;
        step(8);
        chk("game2_back_idle", 32'(bus.state), 0);
        // reset mid-debounce discards progress
        bus.btn_start = 1'b1;
        step(4);
        reset = 1'b0;
        step(1);
        chk("midreset_state", 32'(bus.state), 0);
        chk("midreset_count", 32'(bus.game_count), 0);
        chk("midreset_timer_reset", 32'(bus.timer_reset), 1);
        reset = 1'b1;
        step(6);
        chk("postreset_edge6", 32'(bus.timer_start), 0);
        step(1);
        chk("postreset_edge7", 32'(bus.timer_start), 1);
        chk("postreset_count", 32'(bus.game_count), 1);
        bus.btn_start = 1'b0;
        step(8);
        bus.btn_clear = 1'b1;
        step(8);
        bus.btn_clear = 1'b0;
        step(8);
        chk("postreset_idle", 32'(bus.state), 0);
        // saturation
        for (int i = 0; i < 256; i++) begin
            bus.btn_start = 1'b1;
            step(8);
            if (i == 252) chk("count_254", 32'(bus.game_count), 254);
            bus.btn_start = 1'b0;
            step(8);
            bus.btn_clear = 1'b1;
            step(8);
            bus.btn_clear = 1'b0;
            step(8);
        end
        chk("count_saturated", 32'(bus.game_count), 255);
        bus.btn_start = 1'b1;
        step(8);
        chk("sat_still_runs", 32'(bus.state), 1);
        chk("sat_count", 32'(bus.game_count), 255);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
